// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// The divide-by-zero result is all ones at whatever width the divider is built.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

  localparam int MAX_WIDTH = 64;

  function automatic logic [MAX_WIDTH-1:0] div_zero_result(input int width);
    logic [MAX_WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, and keep or restore the partial remainder.
module divider_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_i, bit_i};
  // rem_i < divisor_i always holds, so the WIDTH+1-bit difference cannot overflow
  assign diff    = shifted - {1'b0, divisor_i};
  assign qbit_o  = ~diff[WIDTH];
  assign rem_o   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];

endmodule

// File: rtl/divider_seq.sv
// Multi-cycle restoring divider with start/busy/done handshake, one quotient bit per clock.
// Signed operation (is_signed port) is compiled in when DIVIDER_SIGNED_EN is defined.
module divider_seq
  import divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIVIDER_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] DBZ_VAL = WIDTH'(div_zero_result(WIDTH));

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic             signed_sel;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;
  logic [WIDTH-1:0] q_raw, q_fix, r_fix;

`ifdef DIVIDER_SIGNED_EN
  assign signed_sel = is_signed;
`else
  assign signed_sel = 1'b0;
`endif

  // Iterate on magnitudes; signs are remembered and reapplied on the final step.
  assign a_neg = signed_sel & dividend[WIDTH-1];
  assign b_neg = signed_sel & divisor[WIDTH-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor : divisor;

  divider_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i    (prem_q),
    .bit_i    (dvd_q[WIDTH-1]),
    .divisor_i(dvs_q),
    .rem_o    (step_rem),
    .qbit_o   (step_qbit)
  );

  assign q_raw = {dvd_q[WIDTH-2:0], step_qbit};
  assign q_fix = negq_q ? -q_raw : q_raw;
  assign r_fix = negr_q ? -step_rem : step_rem;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (divisor == '0) begin
            state_d = DONE;
            quot_d  = DBZ_VAL;
            rem_d   = DBZ_VAL;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = CW'(WIDTH - 1);
            prem_d  = '0;
            dvd_d   = a_mag;
            dvs_d   = b_mag;
            negq_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
          end
        end
      end
      RUN: begin
        prem_d = step_rem;
        dvd_d  = q_raw;
        if (cnt_q == '0) begin
          state_d = DONE;
          quot_d  = q_fix;
          rem_d   = r_fix;
          dbz_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign div_by_zero = dbz_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq at WIDTH=8: arithmetic reference model checked
// every cycle, plus directed transactions with hand-computed results and latencies.
module tb_divider_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         is_signed = 1'b0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  divider_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
`ifdef DIVIDER_SIGNED_EN
    .is_signed  (is_signed),
`endif
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division; returns {div_by_zero, quotient, remainder}.
  function automatic logic [16:0] model_div(input logic [7:0] a, input logic [7:0] b, input bit sgn);
    int sa, sb, iq, ir;
    logic [7:0] q, r;
    if (b == 8'd0) return {1'b1, 8'hFF, 8'hFF};
    if (sgn) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
    end else begin
      sa = int'(a);
      sb = int'(b);
    end
    iq = sa / sb;
    ir = sa % sb;
    q  = iq[7:0];
    r  = ir[7:0];
    return {1'b0, q, r};
  endfunction

  bit sgn_in;
`ifdef DIVIDER_SIGNED_EN
  assign sgn_in = is_signed;
`else
  assign sgn_in = 1'b0;
`endif

  logic [16:0] c_res;
  always_comb c_res = model_div(dividend, divisor, sgn_in);

  // Timeline model: a division occupies W busy cycles then one done cycle;
  // a zero divisor goes straight to the done cycle.
  bit         m_busy, m_done, m_z, p_z;
  int         m_left;
  logic [7:0] m_q, m_r, p_q, p_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
      m_q <= '0; m_r <= '0; m_z <= 1'b0;
      p_q <= '0; p_r <= '0; p_z <= 1'b0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1;
        m_q <= p_q; m_r <= p_r; m_z <= p_z;
      end
    end else if (start) begin
      if (c_res[16]) begin
        m_done <= 1'b1;
        m_q <= c_res[15:8]; m_r <= c_res[7:0]; m_z <= 1'b1;
      end else begin
        m_done <= 1'b0; m_busy <= 1'b1; m_left <= W;
        p_q <= c_res[15:8]; p_r <= c_res[7:0]; p_z <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, m_z});
      chk("quotient", {24'd0, quotient}, {24'd0, m_q});
      chk("remainder", {24'd0, remainder}, {24'd0, m_r});
    end
  end

  int c0;

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit sgn);
    start = 1'b1;
    dividend = a;
    divisor = b;
    is_signed = sgn;
    c0 = cyc;
  endtask

  // Waits (bounded) for done; with hold=1 start stays high and operands churn until done.
  task automatic wait_done(input bit hold, output int lat, output bit busy_seen);
    busy_seen = 1'b0;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      busy_seen = busy_seen | busy;
      if (done) begin
        start = 1'b0;
        lat = cyc - c0;
        break;
      end
      if (hold) begin
        dividend = 8'($urandom_range(0, 255));
        divisor = 8'($urandom_range(1, 255));
      end else begin
        start = 1'b0;
      end
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b, input bit sgn,
                         input logic [7:0] eq, input logic [7:0] er, input bit ez,
                         input int elat, input bit hold);
    int lat;
    bit bs;
    issue(a, b, sgn);
    wait_done(hold, lat, bs);
    chk({tag, "_q"}, {24'd0, quotient}, {24'd0, eq});
    chk({tag, "_r"}, {24'd0, remainder}, {24'd0, er});
    chk({tag, "_z"}, {31'd0, div_by_zero}, {31'd0, ez});
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_busy_seen"}, {31'd0, bs}, {31'd0, !ez});
    $display("txn %s: 0x%02h / 0x%02h signed=%0d -> q=0x%02h r=0x%02h z=%0d lat=%0d",
             tag, a, b, sgn, quotient, remainder, div_by_zero, lat);
  endtask

  initial begin
    int lat;
    int first_c0;
    bit bs;

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    chk("rst_q", {24'd0, quotient}, 32'd0);
    chk("rst_r", {24'd0, remainder}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_div("basic_100_7", 8'd100, 8'd7, 1'b0, 8'd14, 8'd2, 1'b0, 9, 1'b0);
    run_div("dbz_200_0", 8'd200, 8'd0, 1'b0, 8'hFF, 8'hFF, 1'b1, 1, 1'b0);
    run_div("max_255_1", 8'd255, 8'd1, 1'b0, 8'hFF, 8'h00, 1'b0, 9, 1'b0);
    run_div("small_5_9", 8'd5, 8'd9, 1'b0, 8'd0, 8'd5, 1'b0, 9, 1'b0);
    run_div("hold_100_7", 8'd100, 8'd7, 1'b0, 8'd14, 8'd2, 1'b0, 9, 1'b1);
    run_div("u_9c_7", 8'h9C, 8'd7, 1'b0, 8'd22, 8'd2, 1'b0, 9, 1'b0);

    // Back-to-back: second start lands in the first done cycle.
    issue(8'd100, 8'd7, 1'b0);
    first_c0 = c0;
    wait_done(1'b0, lat, bs);
    chk("b2b_first_q", {24'd0, quotient}, 32'd14);
    issue(8'd50, 8'd5, 1'b0);
    wait_done(1'b0, lat, bs);
    chk("b2b_q", {24'd0, quotient}, 32'd10);
    chk("b2b_r", {24'd0, remainder}, 32'd0);
    chk("b2b_done_cycle", cyc - first_c0, 18);
    $display("txn b2b_50_5: q=0x%02h r=0x%02h done_cycle=%0d", quotient, remainder, cyc - first_c0);

    // Reset in cycle 4 of a running division.
    issue(8'd100, 8'd7, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_dbz", {31'd0, div_by_zero}, 32'd0);
    chk("mid_rst_q", {24'd0, quotient}, 32'd0);
    chk("mid_rst_r", {24'd0, remainder}, 32'd0);
    $display("txn mid_reset: busy=%0d done=%0d q=0x%02h r=0x%02h", busy, done, quotient, remainder);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_div("post_rst_9_3", 8'd9, 8'd3, 1'b0, 8'd3, 8'd0, 1'b0, 9, 1'b0);

`ifdef DIVIDER_SIGNED_EN
    run_div("s_m100_7", 8'h9C, 8'd7, 1'b1, 8'hF2, 8'hFE, 1'b0, 9, 1'b0);
    run_div("s_100_m7", 8'd100, 8'hF9, 1'b1, 8'hF2, 8'h02, 1'b0, 9, 1'b0);
    run_div("s_m128_m1", 8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 9, 1'b0);
    run_div("s_dbz", 8'h80, 8'h00, 1'b1, 8'hFF, 8'hFF, 1'b1, 1, 1'b0);
    run_div("s_off_9c_7", 8'h9C, 8'd7, 1'b0, 8'd22, 8'd2, 1'b0, 9, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/divider_seq.md
# divider_seq

Parametrised, multi-cycle restoring divider that replaces the single-cycle combinational 8-bit divider in the CPU datapath. It computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, producing one quotient bit per clock. A start/busy/done handshake lets the control unit stall the ALU while a division is in flight. A divide-by-zero flag replaces the in-band all-ones code, and signed operation can be compiled in.

## Interface
- WIDTH, 8: operand and result width in bits; must be at least 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- dividend  input  WIDTH  captured on an accepted start.
- divisor  input  WIDTH  captured on an accepted start.
- is_signed  input  1  selects two's-complement operation; present only when DIVIDER_SIGNED_EN is defined.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when results become valid.
- div_by_zero  output  1  valid with done; high if the captured divisor was 0.
- quotient  output  WIDTH  registered result, held until the next accepted start.
- remainder  output  WIDTH  registered result, held until the next accepted start.

## Operation
- FSM states:
  - IDLE: start=1 captures the operands and goes to RUN, or to DONE if divisor==0.
  - RUN: WIDTH iterations; a down-counter (ceil(log2(WIDTH+1)) bits) reaches 0, then the FSM goes to DONE.
  - DONE: lasts one cycle. start=1 behaves exactly as in IDLE; otherwise the FSM returns to IDLE.
- Each iteration (restoring):
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor using a WIDTH+1-bit difference.
  - If the difference is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set it to 0.
- Divide by zero: quotient = all ones, remainder = all ones, div_by_zero=1. No RUN cycles.
- start in RUN is ignored; no queueing.
- Operands are sampled only on acceptance. Later input changes do not affect the running division.
- Results (quotient, remainder, div_by_zero) are registered on entry to DONE and held through IDLE.
- Reset mid-operation aborts immediately. No partial result is ever presented.

## Timing
- Reset values: busy=0, done=0, div_by_zero=0, quotient=0, remainder=0, FSM=IDLE, counter=0.
- Cycle numbering: start accepted in cycle 0.
  - Normal division: busy=1 in cycles 1..WIDTH; done=1 in cycle WIDTH+1. Latency is WIDTH+1 cycles; 9 at WIDTH=8.
  - Divide by zero: busy never rises; done=1 in cycle 1.
- Back-to-back: start in the done cycle is accepted.
  - Next busy rises in the following cycle.
  - Throughput is one division per WIDTH+1 cycles.
- done never coincides with busy. Outputs change only on the done edge or on reset.

## Configuration
- DIVIDER_SIGNED_EN defined:
  - Adds the is_signed port.
  - With is_signed=1, operands are converted to magnitudes at capture. The quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
  - Sign fix-up is applied before the DONE register, so latency is unchanged.
  - Most-negative / -1 wraps: quotient = most-negative, remainder = 0.
  - Divide by zero still returns all ones for both results.
- DIVIDER_SIGNED_EN undefined: no is_signed port; unsigned only. Logic is identical to the is_signed=0 path.

## Structure
- Shared package divider_pkg:
  - State typedef div_state_t {IDLE, RUN, DONE}.
  - Function returning the WIDTH-wide all-ones divide-by-zero constant.
- Sub-module divider_step: combinational single restoring step.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new partial remainder, quotient bit.
  - Instantiated once inside the iteration register loop.

## Test plan (WIDTH=8)
- Basic: 100 / 7 → quotient 14, remainder 2, div_by_zero 0; done in cycle 9; busy high in cycles 1-8.
- Divide by zero and boundaries:
  - 200 / 0 → quotient 0xFF, remainder 0xFF, div_by_zero 1, done in cycle 1, busy never high.
  - 255 / 1 → quotient 0xFF, remainder 0x00.
  - 5 / 9 → quotient 0, remainder 5.
- Handshake:
  - start held high throughout RUN with changing operands → only the first division runs.
  - start in the done cycle with 50 / 5 → second result 10 / 0, done in cycle 18.
- Reset mid-operation: rst_n low in cycle 4 → all outputs 0 and FSM in IDLE immediately; a fresh 9 / 3 afterwards → 3 / 0.
- Signed (macro on, is_signed=1):
  - -100 / 7 → quotient 0xF2, remainder 0xFE.
  - 100 / -7 → quotient 0xF2, remainder 0x02.
  - -128 / -1 → quotient 0x80, remainder 0x00.
- Unsigned with macro on: is_signed=0, 0x9C / 7 → quotient 22, remainder 2.
